frame_send_buffer: RTL and testbench

- Parametrised single-clock successor to the packet output buffer between the trace packet processor and the upstream link (serial/USB).
- Accepts W-bit words and commits them to the reader only in whole frames of 2^FRAMELOG2 words.
- Supports write-side abort to the last committed frame, read-side rewind to the current frame start, and a sticky overflow lock with stretched indication.
- Uses extra-bit pointers so the full depth is usable, and protects the frame being read against overwrite so a rewind always succeeds.

---
 rtl/frame_send_pkg.sv | 28 ++
 rtl/frame_send_buffer_if.sv | 32 +++
 rtl/frame_send_ram.sv | 38 +++
 rtl/frame_send_buffer.sv | 115 +++++++++++
 tb/tb_frame_send_buffer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/frame_send_pkg.sv
// Shared helpers for the frame send buffer: pointer sizing and frame alignment.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package frame_send_pkg;

    // Default geometry; instances derive their own values through the functions below.
    localparam int DEF_FRAMELOG2 = 3;
    localparam int DEF_DEPTHLOG2 = 12;
    localparam int PTRW  = DEF_DEPTHLOG2 + 1;
    localparam int FRAME = 1 << DEF_FRAMELOG2;

    // One extra wrap bit lets full and empty be told apart at full depth.
    function automatic int ptr_width(input int depthlog2);
        return depthlog2 + 1;
    endfunction

    function automatic int frame_words(input int framelog2);
        return 1 << framelog2;
    endfunction

    // Clears the word-within-frame bits, giving the start of the frame holding ptr.
    function automatic logic [31:0] align_frame(input logic [31:0] ptr, input int framelog2);
        logic [31:0] mask;
        mask = (32'd1 << framelog2) - 32'd1;
        return ptr & ~mask;
    endfunction

endpackage

// File: rtl/frame_send_buffer_if.sv
// Bundles the write, read and status signals of the frame send buffer.
// Latency: none (wiring only).
// Backpressure: the producer watches ovf/fill_level; the consumer watches rd_avail/frame_ready.
interface frame_send_buffer_if #(
    parameter int W         = 16,
    parameter int DEPTHLOG2 = 12
);
    logic                 sync;
    logic                 wr_en;
    logic [W-1:0]         wr_data;
    logic                 wr_abort;
    logic                 rd_next;
    logic                 rd_rewind;
    logic [W-1:0]         rd_data;
    logic                 rd_data_valid;
    logic                 rd_avail;
    logic                 frame_ready;
    logic [DEPTHLOG2:0]   fill_level;
    logic                 ovf;

    // Side driving words in and pulling words out.
    modport master (
        output sync, wr_en, wr_data, wr_abort, rd_next, rd_rewind,
        input  rd_data, rd_data_valid, rd_avail, frame_ready, fill_level, ovf
    );

    // The buffer itself.
    modport slave (
        input  sync, wr_en, wr_data, wr_abort, rd_next, rd_rewind,
        output rd_data, rd_data_valid, rd_avail, frame_ready, fill_level, ovf
    );
endinterface

// File: rtl/frame_send_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: read data appears one clock after re.
// Backpressure: none; the read register holds its value when re is low.
module frame_send_ram #(
    parameter int W  = 16,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [W-1:0]  rd
);
    logic [W-1:0] mem [2**AW];
    logic [W-1:0] rd_d, rd_q;

    // Storage array is not reset so it can live in block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    // Hold the last read word unless a new read is requested.
    always_comb begin
        rd_d = rd_q;
        if (re) rd_d = mem[ra];
    end

    // Output register clears on reset so rd_data reads 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_q <= '0;
        else      rd_q <= rd_d;
    end

    assign rd = rd_q;
endmodule

// File: rtl/frame_send_buffer.sv
// Frame-committing word buffer with write abort, read rewind and sticky overflow lock.
// Latency: a word is readable the cycle after its frame completes; read data 1 cycle after rd_next.
// Backpressure: writes into a full buffer set the overflow lock and are dropped until abort/sync loss.
module frame_send_buffer
    import frame_send_pkg::*;
#(
    parameter int W         = 16,
    parameter int FRAMELOG2 = 3,
    parameter int DEPTHLOG2 = 12,
    parameter int OVFLOG2   = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    frame_send_buffer_if.slave   bus
);
    localparam int PW    = ptr_width(DEPTHLOG2);
    localparam int DEPTH = 1 << DEPTHLOG2;

    logic [PW-1:0]      wp_d, wp_q, cp_d, cp_q, rp_d, rp_q;
    logic [PW-1:0]      rp_base, used, wp_inc;
    logic               ovf_lock_d, ovf_lock_q;
    logic               sync_d, sync_q;
    logic               rd_data_valid_d, rd_data_valid_q;
    logic [OVFLOG2-1:0] stretch_d, stretch_q;
    logic               full, abort, ram_we, ram_re, rd_avail;

    // Free space is counted from the start of the frame being read, so a rewind
    // can never land on slots that were handed back to the writer.
    assign rp_base  = PW'(align_frame(32'(rp_q), FRAMELOG2));
    assign used     = wp_q - rp_base;
    assign full     = (used == PW'(DEPTH));
    assign wp_inc   = wp_q + PW'(1);
    assign rd_avail = (rp_q != cp_q);
    assign abort    = bus.wr_abort | (sync_q & ~bus.sync);

    // Write side: abort beats overflow beats store; commit on each completed frame.
    always_comb begin
        wp_d       = wp_q;
        cp_d       = cp_q;
        ovf_lock_d = ovf_lock_q;
        ram_we     = 1'b0;
        sync_d     = bus.sync;
        if (abort) begin
            wp_d       = cp_q;
            ovf_lock_d = 1'b0;
        end else if (bus.wr_en && bus.sync && !ovf_lock_q) begin
            if (full) begin
                ovf_lock_d = 1'b1;
            end else begin
                ram_we = 1'b1;
                wp_d   = wp_inc;
                if (wp_inc[FRAMELOG2-1:0] == '0) cp_d = wp_inc;
            end
        end
    end

    // Read side: rewind wins over a read strobe; reads only touch committed words.
    always_comb begin
        rp_d            = rp_q;
        ram_re          = 1'b0;
        rd_data_valid_d = 1'b0;
        if (bus.rd_rewind) begin
            rp_d = rp_base;
        end else if (bus.rd_next && rd_avail) begin
            ram_re          = 1'b1;
            rp_d            = rp_q + PW'(1);
            rd_data_valid_d = 1'b1;
        end
    end

    // Overflow indication is held high while locked and then decays to zero.
    always_comb begin
        stretch_d = stretch_q;
        if (ovf_lock_q || ovf_lock_d)    stretch_d = '1;
        else if (stretch_q != '0)        stretch_d = stretch_q - OVFLOG2'(1);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q            <= '0;
            cp_q            <= '0;
            rp_q            <= '0;
            ovf_lock_q      <= 1'b0;
            sync_q          <= 1'b0;
            rd_data_valid_q <= 1'b0;
            stretch_q       <= '0;
        end else begin
            wp_q            <= wp_d;
            cp_q            <= cp_d;
            rp_q            <= rp_d;
            ovf_lock_q      <= ovf_lock_d;
            sync_q          <= sync_d;
            rd_data_valid_q <= rd_data_valid_d;
            stretch_q       <= stretch_d;
        end
    end

    frame_send_ram #(.W(W), .AW(DEPTHLOG2)) u_ram (
        .clk (clk),
        .rst (rst),
        .we  (ram_we),
        .wa  (wp_q[DEPTHLOG2-1:0]),
        .wd  (bus.wr_data),
        .re  (ram_re),
        .ra  (rp_q[DEPTHLOG2-1:0]),
        .rd  (bus.rd_data)
    );

    assign bus.rd_data_valid = rd_data_valid_q;
    assign bus.rd_avail      = rd_avail;
    assign bus.frame_ready   = (cp_q >> FRAMELOG2) != (rp_q >> FRAMELOG2);
    assign bus.fill_level    = used;
    assign bus.ovf           = (stretch_q != '0);
endmodule

// File: tb/tb_frame_send_buffer.sv
// Directed bench for frame_send_buffer: commit, abort, rewind, overflow, sync loss, reset.
// Latency: checks are taken 1 ns after each rising edge.
// Backpressure: exercised by filling to depth and overflowing.
module tb_frame_send_buffer;
    localparam int W = 16, FL2 = 3, DL2 = 5, OL2 = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    frame_send_buffer_if #(.W(W), .DEPTHLOG2(DL2)) bus ();

    frame_send_buffer #(.W(W), .FRAMELOG2(FL2), .DEPTHLOG2(DL2), .OVFLOG2(OL2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] exp);
        bus.rd_next = 1'b1;
        tick();
        bus.rd_next = 1'b0;
        chk({tag, "_vld"}, 32'(bus.rd_data_valid), 32'd1);
        chk({tag, "_dat"}, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_data"},  32'(bus.rd_data), 32'd0);
        chk({tag, "_vld"},   32'(bus.rd_data_valid), 32'd0);
        chk({tag, "_avail"}, 32'(bus.rd_avail), 32'd0);
        chk({tag, "_frdy"},  32'(bus.frame_ready), 32'd0);
        chk({tag, "_fill"},  32'(bus.fill_level), 32'd0);
        chk({tag, "_ovf"},   32'(bus.ovf), 32'd0);
    endtask

    initial begin
        bus.sync = 1'b1; bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_abort = 1'b0;
        bus.rd_next = 1'b0; bus.rd_rewind = 1'b0;

        // Reset state
        #12;
        outs_zero("reset");
        rst = 1'b1;
        tick();

        // Commit: nothing visible until the 8th word
        for (int i = 1; i <= 7; i++) wr(16'(i));
        chk("commit_avail7", 32'(bus.rd_avail), 32'd0);
        chk("commit_frdy7", 32'(bus.frame_ready), 32'd0);
        chk("commit_fill7", 32'(bus.fill_level), 32'd7);
        wr(16'h0008);
        chk("commit_avail8", 32'(bus.rd_avail), 32'd1);
        chk("commit_frdy8", 32'(bus.frame_ready), 32'd1);
        chk("commit_fill8", 32'(bus.fill_level), 32'd8);
        for (int i = 1; i <= 8; i++) rd_chk("commit_rd", 16'(i));
        tick();
        chk("commit_vld_drop", 32'(bus.rd_data_valid), 32'd0);
        chk("commit_drained", 32'(bus.rd_avail), 32'd0);

        // Abort: uncommitted tail discarded, committed frame untouched
        for (int i = 0; i < 8; i++) wr(16'h0011 + 16'(i));
        for (int i = 0; i < 5; i++) wr(16'h0021 + 16'(i));
        chk("abort_fill_pre", 32'(bus.fill_level), 32'd13);
        bus.wr_abort = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 16'hDEAD;
        tick();
        bus.wr_abort = 1'b0; bus.wr_en = 1'b0;
        chk("abort_fill", 32'(bus.fill_level), 32'd8);
        chk("abort_avail", 32'(bus.rd_avail), 32'd1);
        for (int i = 0; i < 8; i++) wr(16'h0031 + 16'(i));
        chk("abort_fill16", 32'(bus.fill_level), 32'd16);
        for (int i = 0; i < 8; i++) rd_chk("abort_old", 16'h0011 + 16'(i));
        for (int i = 0; i < 8; i++) rd_chk("abort_new", 16'h0031 + 16'(i));

        // Rewind: mid-frame returns to frame start, on boundary is a no-op
        for (int i = 1; i <= 16; i++) wr(16'(i));
        for (int i = 1; i <= 5; i++) rd_chk("rew_a", 16'(i));
        bus.rd_rewind = 1'b1; bus.rd_next = 1'b1;
        tick();
        bus.rd_rewind = 1'b0; bus.rd_next = 1'b0;
        chk("rew_no_out", 32'(bus.rd_data_valid), 32'd0);
        chk("rew_fill", 32'(bus.fill_level), 32'd16);
        for (int i = 1; i <= 8; i++) rd_chk("rew_b", 16'(i));
        bus.rd_rewind = 1'b1;
        tick();
        bus.rd_rewind = 1'b0;
        chk("rew_bound_fill", 32'(bus.fill_level), 32'd8);
        for (int i = 9; i <= 16; i++) rd_chk("rew_c", 16'(i));

        // Full and overflow (pointers now sit past the wrap point)
        for (int i = 0; i < 32; i++) wr(16'h0100 + 16'(i));
        chk("full_fill", 32'(bus.fill_level), 32'd32);
        chk("full_ovf0", 32'(bus.ovf), 32'd0);
        wr(16'hBAD0);
        chk("ovf_set", 32'(bus.ovf), 32'd1);
        chk("ovf_fill", 32'(bus.fill_level), 32'd32);
        wr(16'hBAD1);
        chk("ovf_locked_fill", 32'(bus.fill_level), 32'd32);
        bus.wr_abort = 1'b1;
        tick();
        bus.wr_abort = 1'b0;
        chk("ovf_abort_fill", 32'(bus.fill_level), 32'd32);
        for (int i = 0; i < 14; i++) tick();
        chk("ovf_stretch_hi", 32'(bus.ovf), 32'd1);
        tick();
        chk("ovf_stretch_lo", 32'(bus.ovf), 32'd0);
        for (int i = 0; i < 32; i++) rd_chk("ovf_rd", 16'h0100 + 16'(i));
        chk("ovf_drained", 32'(bus.fill_level), 32'd0);

        // Sync loss drops the partial frame and blocks writes while low
        for (int i = 0; i < 3; i++) wr(16'h0201 + 16'(i));
        chk("sync_fill3", 32'(bus.fill_level), 32'd3);
        bus.sync = 1'b0;
        tick();
        chk("sync_fall", 32'(bus.fill_level), 32'd0);
        wr(16'hBEEF);
        chk("sync_low_wr", 32'(bus.fill_level), 32'd0);
        bus.sync = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) wr(16'h0301 + 16'(i));
        chk("sync_refill", 32'(bus.fill_level), 32'd8);
        rd_chk("sync_rd", 16'h0301);

        // Asynchronous reset mid-frame with a read in flight
        for (int i = 1; i < 8; i++) rd_chk("rst_pre", 16'h0301 + 16'(i));
        for (int i = 0; i < 8; i++) wr(16'h0401 + 16'(i));
        for (int i = 0; i < 3; i++) wr(16'h0501 + 16'(i));
        bus.rd_next = 1'b1;
        tick();
        chk("rst_pre_vld", 32'(bus.rd_data_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        outs_zero("rst_async");
        #3 rst = 1'b1;
        bus.rd_next = 1'b0;
        tick();
        chk("rst_avail", 32'(bus.rd_avail), 32'd0);
        chk("rst_fill", 32'(bus.fill_level), 32'd0);
        for (int i = 0; i < 8; i++) wr(16'h0601 + 16'(i));
        chk("rst_refill", 32'(bus.fill_level), 32'd8);
        rd_chk("rst_rd", 16'h0601);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
